// File: rtl/enigma_message_sequencer_pkg.sv
// Shared definitions for the Enigma message sequencer: ASCII codes, FSM states,
// FIFO entry layout and small character-class helpers.
package enigma_message_sequencer_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_UP_A  = 8'h41;
  localparam logic [7:0] ASCII_UP_Z  = 8'h5A;
  localparam logic [7:0] ASCII_LO_A  = 8'h61;
  localparam logic [7:0] ASCII_LO_Z  = 8'h7A;

  localparam int unsigned CHAR_W  = 8;
  localparam int unsigned POS_W   = 5;
  localparam int unsigned ENTRY_W = 1 + CHAR_W + 3 * POS_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEP,
    ST_RUN,
    ST_GAP
  } state_t;

  typedef struct packed {
    logic              start;
    logic [CHAR_W-1:0] chr;
    logic [POS_W-1:0]  pos1;
    logic [POS_W-1:0]  pos2;
    logic [POS_W-1:0]  pos3;
  } entry_t;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= ASCII_UP_A) && (c <= ASCII_UP_Z);
  endfunction

  function automatic logic is_lower(input logic [7:0] c);
    return (c >= ASCII_LO_A) && (c <= ASCII_LO_Z);
  endfunction

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    return is_lower(c) ? (c - (ASCII_LO_A - ASCII_UP_A)) : c;
  endfunction

endpackage

// File: rtl/msg_fifo.sv
// Synchronous FIFO with wrap-bit pointers; exposes the head entry and the MSB
// (flag bit) of the entry behind it so the consumer can look one ahead.
module msg_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             next_flag,
  output logic             full,
  output logic             empty,
  output logic             has_second
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      rd_next;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty      = (wr_ptr == rd_ptr);
  assign count      = wr_ptr - rd_ptr;
  assign has_second = (count >= (AW+1)'(2));
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign rd_next    = rd_ptr + 1'b1;
  assign head_data  = mem[rd_ptr[AW-1:0]];
  assign next_flag  = mem[rd_next[AW-1:0]][WIDTH-1];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/enigma_message_sequencer.sv
// Feeds buffered, upper-cased letters through an external Enigma core and emits
// the cipher stream in fixed-length groups, with a newline between messages.
module enigma_message_sequencer
  import enigma_message_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned GROUP_LEN = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_char,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       msg_start,
  input  logic [4:0] startPosition1,
  input  logic [4:0] startPosition2,
  input  logic [4:0] startPosition3,
  output logic [7:0] enig_char,
  output logic       enig_load,
  output logic [4:0] enig_pos1,
  output logic [4:0] enig_pos2,
  output logic [4:0] enig_pos3,
  output logic       enig_advance,
  input  logic [7:0] enig_out_char,
  output logic [7:0] out_char,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int unsigned GW = $clog2(GROUP_LEN + 1);

  state_t state, state_next;

  logic [GW-1:0] grp_cnt;
  logic          grp_clr;
  logic          grp_inc;
  logic          prior_msg;

  logic          pend_start;
  logic [4:0]    pend_pos1;
  logic [4:0]    pend_pos2;
  logic [4:0]    pend_pos3;

  logic          accept;
  logic          is_letter;
  logic          push;
  logic          pop;
  entry_t        in_entry;
  entry_t        head;
  logic [ENTRY_W-1:0] head_data;
  logic          next_start;
  logic          full;
  logic          empty;
  logic          has_second;

  logic          out_free;
  logic          out_wr;
  logic [7:0]    out_wr_char;

  assign in_ready  = !full;
  assign accept    = in_valid && in_ready;
  assign is_letter = is_upper(in_char) || is_lower(in_char);
  assign push      = accept && is_letter;
  assign head      = entry_t'(head_data);
  assign out_free  = !out_valid || out_ready;

  always_comb begin
    in_entry.start = msg_start || pend_start;
    in_entry.chr   = to_upper(in_char);
    in_entry.pos1  = msg_start ? startPosition1 : pend_pos1;
    in_entry.pos2  = msg_start ? startPosition2 : pend_pos2;
    in_entry.pos3  = msg_start ? startPosition3 : pend_pos3;
  end

  // A message start seen on a discarded character waits for the next letter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_start <= 1'b0;
      pend_pos1  <= '0;
      pend_pos2  <= '0;
      pend_pos3  <= '0;
    end else if (accept) begin
      if (is_letter) begin
        pend_start <= 1'b0;
      end else if (msg_start) begin
        pend_start <= 1'b1;
        pend_pos1  <= startPosition1;
        pend_pos2  <= startPosition2;
        pend_pos3  <= startPosition3;
      end
    end
  end

  msg_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_data  (in_entry),
    .pop        (pop),
    .head_data  (head_data),
    .next_flag  (next_start),
    .full       (full),
    .empty      (empty),
    .has_second (has_second)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    pop          = 1'b0;
    enig_load    = 1'b0;
    enig_advance = 1'b0;
    enig_char    = '0;
    enig_pos1    = '0;
    enig_pos2    = '0;
    enig_pos3    = '0;
    out_wr       = 1'b0;
    out_wr_char  = '0;
    grp_clr      = 1'b0;
    grp_inc      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!empty && out_free) begin
          if (head.start) state_next = prior_msg ? ST_SEP : ST_LOAD;
          else            state_next = ST_RUN;
        end
      end
      ST_SEP: begin
        if (out_free) begin
          out_wr      = 1'b1;
          out_wr_char = ASCII_LF;
          state_next  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        enig_load  = 1'b1;
        enig_pos1  = head.pos1;
        enig_pos2  = head.pos2;
        enig_pos3  = head.pos3;
        grp_clr    = 1'b1;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if ((grp_cnt == GW'(GROUP_LEN)) && !head.start) begin
          state_next = ST_GAP;
        end else if (out_free) begin
          enig_advance = 1'b1;
          enig_char    = head.chr;
          pop          = 1'b1;
          out_wr       = 1'b1;
          out_wr_char  = enig_out_char;
          grp_inc      = 1'b1;
          // Stay in RUN when the following entry continues the same message,
          // which is what IDLE would decide next cycle; saves the bubble.
          state_next   = (has_second && !next_start) ? ST_RUN : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (out_free) begin
          out_wr      = 1'b1;
          out_wr_char = ASCII_SPACE;
          grp_clr     = 1'b1;
          state_next  = ST_RUN;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grp_cnt   <= '0;
      prior_msg <= 1'b0;
    end else begin
      if (grp_clr)      grp_cnt <= '0;
      else if (grp_inc) grp_cnt <= grp_cnt + 1'b1;
      if (enig_advance) prior_msg <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_char  <= '0;
    end else if (out_wr) begin
      out_valid <= 1'b1;
      out_char  <= out_wr_char;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_enigma_message_sequencer.sv
// Bench for enigma_message_sequencer: directed scenarios plus random traffic
// checked against a stream-level reference model with a stub Enigma core.
module tb_enigma_message_sequencer;

  localparam int unsigned DEPTH     = 8;
  localparam int unsigned GROUP_LEN = 5;

  logic       clock;
  logic       reset;
  logic [7:0] in_char;
  logic       in_valid;
  logic       in_ready;
  logic       msg_start;
  logic [4:0] startPosition1, startPosition2, startPosition3;
  logic [7:0] enig_char;
  logic       enig_load;
  logic [4:0] enig_pos1, enig_pos2, enig_pos3;
  logic       enig_advance;
  logic [7:0] enig_out_char;
  logic [7:0] out_char;
  logic       out_valid;
  logic       out_ready;

  // Stub core: next letter of the alphabet, wrapping Z to A.
  assign enig_out_char = (enig_char == 8'h5A) ? 8'h41 : enig_char + 8'd1;

  enigma_message_sequencer #(
    .DEPTH     (DEPTH),
    .GROUP_LEN (GROUP_LEN)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .in_char        (in_char),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .msg_start      (msg_start),
    .startPosition1 (startPosition1),
    .startPosition2 (startPosition2),
    .startPosition3 (startPosition3),
    .enig_char      (enig_char),
    .enig_load      (enig_load),
    .enig_pos1      (enig_pos1),
    .enig_pos2      (enig_pos2),
    .enig_pos3      (enig_pos3),
    .enig_advance   (enig_advance),
    .enig_out_char  (enig_out_char),
    .out_char       (out_char),
    .out_valid      (out_valid),
    .out_ready      (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0]  exp_out  [$];
  logic [7:0]  exp_enig [$];
  logic [14:0] exp_load [$];
  logic [7:0]  captured [$];
  bit          m_pend;
  logic [14:0] m_pend_pos;
  bit          m_prior;
  int          m_group;

  int  loads_seen;
  int  adv_seen;
  bit  prev_hold;
  logic [7:0] prev_char;
  int  rdy_mode;   // 0: hold low, 1: hold high, 2: random

  function automatic void model_clear();
    exp_out.delete();
    exp_enig.delete();
    exp_load.delete();
    captured.delete();
    m_pend     = 0;
    m_pend_pos = '0;
    m_prior    = 0;
    m_group    = 0;
    loads_seen = 0;
    adv_seen   = 0;
  endfunction

  function automatic void model_accept(input logic [7:0] c, input bit st, input logic [14:0] pos);
    logic [7:0]  u;
    logic [14:0] p;
    bit          start;
    if (c >= 8'h61 && c <= 8'h7A)      u = c - 8'h20;
    else if (c >= 8'h41 && c <= 8'h5A) u = c;
    else begin
      if (st) begin
        m_pend     = 1;
        m_pend_pos = pos;
      end
      return;
    end
    start  = st || m_pend;
    p      = st ? pos : m_pend_pos;
    m_pend = 0;
    if (start) begin
      if (m_prior) exp_out.push_back(8'h0A);
      exp_load.push_back(p);
      m_group = 0;
    end else if (m_group == GROUP_LEN) begin
      exp_out.push_back(8'h20);
      m_group = 0;
    end
    exp_enig.push_back(u);
    exp_out.push_back((u == 8'h5A) ? 8'h41 : u + 8'd1);
    m_group++;
    m_prior = 1;
  endfunction

  // Output-ready driver
  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_hold = 0;
      end else begin
        check("load_adv_excl", 32'(enig_load & enig_advance), 0);
        if (!enig_load && !enig_advance) check("enig_char_idle", enig_char, 0);
        if (enig_load) begin
          loads_seen++;
          if (exp_load.size() == 0) check("load_extra", 1, 0);
          else check("load_pos", {enig_pos1, enig_pos2, enig_pos3}, exp_load.pop_front());
        end
        if (enig_advance) begin
          adv_seen++;
          if (exp_enig.size() == 0) check("advance_extra", 1, 0);
          else check("enig_char", enig_char, exp_enig.pop_front());
        end
        if (prev_hold) begin
          check("out_hold_valid", out_valid, 1);
          check("out_hold_char", out_char, prev_char);
        end
        if (out_valid && out_ready) begin
          captured.push_back(out_char);
          if (exp_out.size() == 0) check("out_extra", 1, 0);
          else check("out_char", out_char, exp_out.pop_front());
        end
        prev_hold = out_valid && !out_ready;
        prev_char = out_char;
      end
    end
  end

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    msg_start = 1'b0;
    model_clear();
    prev_hold = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic send_char(input logic [7:0] c, input bit st, input logic [14:0] pos);
    bit acc = 0;
    in_char        = c;
    in_valid       = 1'b1;
    msg_start      = st;
    startPosition1 = pos[14:10];
    startPosition2 = pos[9:5];
    startPosition3 = pos[4:0];
    for (int n = 0; n < 300 && !acc; n++) begin
      @(negedge clock);
      if (in_ready) acc = 1;
      @(posedge clock);
    end
    if (acc) model_accept(c, st, pos);
    else check("in_ready_timeout", 0, 1);
    #1;
    in_valid  = 1'b0;
    msg_start = 1'b0;
  endtask

  task automatic send_str(input string s, input bit st, input logic [14:0] pos);
    for (int i = 0; i < s.len(); i++) send_char(s[i], st && (i == 0), pos);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_out.size() != 0) && (n < 3000)) begin
      @(negedge clock);
      n++;
    end
    repeat (4) @(negedge clock);
    check("drain_out", exp_out.size(), 0);
    check("drain_enig", exp_enig.size(), 0);
    #1;
  endtask

  task automatic expect_captured(input string tag, input string s);
    check({tag, "_len"}, captured.size(), s.len());
    for (int i = 0; i < s.len() && i < captured.size(); i++) check(tag, captured[i], s[i]);
  endtask

  function automatic logic [7:0] rand_char();
    logic [7:0] odd [10] = '{8'h40, 8'h5B, 8'h60, 8'h7B, 8'h20, 8'h2D, 8'h30, 8'h00, 8'h7F, 8'hC1};
    int unsigned k = $urandom_range(0, 99);
    if (k < 60)      return 8'h41 + 8'($urandom_range(0, 25));
    else if (k < 85) return 8'h61 + 8'($urandom_range(0, 25));
    else             return odd[$urandom_range(0, 9)];
  endfunction

  function automatic logic [14:0] rand_pos();
    return {5'($urandom_range(0, 25)), 5'($urandom_range(0, 25)), 5'($urandom_range(0, 25))};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_char = '0; msg_start = 1'b0;
    startPosition1 = '0; startPosition2 = '0; startPosition3 = '0;
    out_ready = 1'b1;
    rdy_mode  = 1;
    do_reset();

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_char", out_char, 0);
    check("rst_enig_load", enig_load, 0);
    check("rst_enig_advance", enig_advance, 0);
    check("rst_enig_char", enig_char, 0);
    check("rst_enig_pos", {enig_pos1, enig_pos2, enig_pos3}, 0);

    // Message start with positions, then plain letters
    send_char("K", 1, {5'd24, 5'd25, 5'd25});
    send_str("ADI", 0, '0);
    drain();
    expect_captured("kadi", "LBEJ");
    check("kadi_loads", loads_seen, 1);
    check("kadi_advances", adv_seen, 4);

    // Non-letter dropped mid-stream
    do_reset();
    send_str("h-i", 0, '0);
    drain();
    expect_captured("h_i", "IJ");
    check("h_i_loads", loads_seen, 0);

    // Grouping, no trailing space
    do_reset();
    send_str("ABCDEFGHIJKL", 0, '0);
    drain();
    expect_captured("groups", "BCDEF GHIJK LM");

    // Two messages separated by newline
    do_reset();
    send_str("AB", 1, {5'd3, 5'd4, 5'd5});
    send_char("Z", 1, '0);
    drain();
    expect_captured("two_msg", "BC\nA");
    check("two_msg_loads", loads_seen, 2);

    // msg_start on a discarded character carries to the next letter
    do_reset();
    send_str("Q", 0, '0);
    send_char("#", 1, {5'd7, 5'd8, 5'd9});
    send_str("r", 0, '0);
    drain();
    expect_captured("carry", "R\nS");
    check("carry_loads", loads_seen, 1);

    // Backpressure: 8 FIFO entries + 1 output register
    do_reset();
    rdy_mode  = 0;
    out_ready = 1'b0;
    send_str("ABCDEFGHI", 0, '0);
    repeat (3) @(negedge clock);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    rdy_mode = 1;
    @(posedge clock); #1;
    send_char("J", 0, '0);
    drain();
    expect_captured("bp", "BCDEF GHIJK");

    // Reset with data buffered and output held
    do_reset();
    rdy_mode  = 0;
    out_ready = 1'b0;
    send_str("ABCD", 0, '0);
    repeat (4) @(negedge clock);
    check("mid_out_valid_before", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_out_valid", out_valid, 0);
    check("mid_in_ready", in_ready, 1);
    check("mid_advance", enig_advance, 0);
    model_clear();
    prev_hold = 0;
    rdy_mode  = 1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("post_rst_quiet", {30'd0, out_valid, enig_advance}, 0);
    end
    @(posedge clock); #1;

    // Random traffic
    do_reset();
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      send_char(rand_char(), ($urandom_range(0, 7) == 0), rand_pos());
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock); #1;
      end
    end
    rdy_mode = 1;
    drain();
    check("rand_loads_left", exp_load.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
